// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, immediate-select codes and the
// buffer entry/state types used by the decode-stage controller.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_J    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_B    = 3'b100;
    localparam logic [2:0] IMM_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      immSel;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    typedef struct packed {
        logic [2:0] immSel;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/imm_decode_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode controller.
interface imm_decode_ctrl_if;
    import rv32i_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_immSel;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_immSel, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_imm, out_immSel, out_pc, out_illegal
    );

endinterface

// File: rtl/imm_decode_ctrl_immgen.sv
// ImmGen: builds the sign-extended immediate from instr[31:7]; dataIn_i[k]
// corresponds to instr[k+7]. U-type is returned unshifted.
module ImmGen
    import rv32i_pkg::*;
(
    input  logic [24:0]     dataIn_i,
    input  logic [2:0]      immSel_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (immSel_i)
            IMM_I: imm_o = {{20{dataIn_i[24]}}, dataIn_i[24:13]};
            IMM_S: imm_o = {{20{dataIn_i[24]}}, dataIn_i[24:18], dataIn_i[4:0]};
            IMM_B: imm_o = {{19{dataIn_i[24]}}, dataIn_i[24], dataIn_i[0],
                            dataIn_i[23:18], dataIn_i[4:1], 1'b0};
            IMM_U: imm_o = {{12{dataIn_i[24]}}, dataIn_i[24:5]};
            IMM_J: imm_o = {{11{dataIn_i[24]}}, dataIn_i[24], dataIn_i[12:5],
                            dataIn_i[13], dataIn_i[23:14], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: decodes the opcode, runs ImmGen on the incoming
// instruction and hands results to execute through a 2-entry skid buffer.
module imm_decode_ctrl
    import rv32i_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    imm_decode_ctrl_if.slave   ctrl_if
);

    function automatic decode_t decodeOp(input logic [6:0] opcode);
        decode_t d;
        d.immSel  = IMM_NONE;
        d.illegal = 1'b0;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM, FENCE: d.immSel = IMM_I;
            JAL:                               d.immSel = IMM_J;
            STORE:                             d.immSel = IMM_S;
            LUI, AUIPC:                        d.immSel = IMM_U;
            BRANCH:                            d.immSel = IMM_B;
            OP:                                d.immSel = IMM_NONE;
            default:                           d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    buf_state_e      state_q, state_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    decode_t         dec;
    logic [XLEN-1:0] genImm;
    entry_t          newEntry;
    logic            accept;
    logic            drain;

    assign dec = decodeOp(ctrl_if.in_instr[6:0]);

    ImmGen u_immgen (
        .dataIn_i (ctrl_if.in_instr[31:7]),
        .immSel_i (dec.immSel),
        .imm_o    (genImm)
    );

    // IMM_NONE already yields zero from ImmGen, covering both R-type and illegal.
    always_comb begin
        newEntry.imm     = genImm;
        newEntry.immSel  = dec.immSel;
        newEntry.pc      = ctrl_if.in_pc;
        newEntry.illegal = dec.illegal;
    end

    assign ctrl_if.in_ready    = (state_q != ST_TWO);
    assign ctrl_if.out_valid   = (state_q != ST_EMPTY);
    assign ctrl_if.out_imm     = main_q.imm;
    assign ctrl_if.out_immSel  = main_q.immSel;
    assign ctrl_if.out_pc      = main_q.pc;
    assign ctrl_if.out_illegal = main_q.illegal;

    assign accept = ctrl_if.in_valid & ctrl_if.in_ready;
    assign drain  = ctrl_if.out_valid & ctrl_if.out_ready;

    // Flush wins over everything; otherwise the main entry always holds the
    // oldest instruction and the skid entry only fills while execute stalls.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (ctrl_if.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = newEntry;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = newEntry;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = newEntry;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed self-checking bench for imm_decode_ctrl with hand-computed
// immediates, stall/skid, flush, illegal opcode and async reset cases.
module tb_imm_decode_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    imm_decode_ctrl_if bus ();

    imm_decode_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc);
        bus.in_valid = valid;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkEntry(input string tag, input logic [2:0] sel,
                              input logic [31:0] imm, input logic [31:0] pc,
                              input logic illegal);
        checkOutput({tag, ".valid"},   32'(bus.out_valid),   32'd1);
        checkOutput({tag, ".immSel"},  32'(bus.out_immSel),  32'(sel));
        checkOutput({tag, ".imm"},     bus.out_imm,          imm);
        checkOutput({tag, ".pc"},      bus.out_pc,           pc);
        checkOutput({tag, ".illegal"}, 32'(bus.out_illegal), 32'(illegal));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".valid"},   32'(bus.out_valid),   32'd0);
        checkOutput({tag, ".ready"},   32'(bus.in_ready),    32'd1);
        checkOutput({tag, ".imm"},     bus.out_imm,          32'd0);
        checkOutput({tag, ".immSel"},  32'(bus.out_immSel),  32'd0);
        checkOutput({tag, ".pc"},      bus.out_pc,           32'd0);
        checkOutput({tag, ".illegal"}, 32'(bus.out_illegal), 32'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        #11;
        checkReset("reset");
        #1;
        rst_n = 1'b1;

        // First edge after deassert accepts immediately.
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'hFFF00093, 32'h0000_0100);
        checkEntry("addi", 3'b000, 32'hFFFF_FFFF, 32'h0000_0100, 1'b0);

        applyStimulus(1'b1, 32'h0080006F, 32'h0000_0104);
        checkEntry("jal", 3'b001, 32'h0000_0008, 32'h0000_0104, 1'b0);
        checkOutput("jal.ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 32'h00112423, 32'h0000_0108);
        checkEntry("sw", 3'b010, 32'h0000_0008, 32'h0000_0108, 1'b0);
        applyStimulus(1'b1, 32'hFE000EE3, 32'h0000_010C);
        checkEntry("beq", 3'b100, 32'hFFFF_FFFC, 32'h0000_010C, 1'b0);
        applyStimulus(1'b1, 32'h123450B7, 32'h0000_0110);
        checkEntry("lui", 3'b011, 32'h0001_2345, 32'h0000_0110, 1'b0);
        checkOutput("lui.ready", 32'(bus.in_ready), 32'd1);

        // Stall three cycles: only one more fits behind the LUI.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00500113, 32'h0000_0200);
        checkOutput("stall1.ready", 32'(bus.in_ready), 32'd0);
        checkEntry("stall1", 3'b011, 32'h0001_2345, 32'h0000_0110, 1'b0);
        applyStimulus(1'b1, 32'h00A00193, 32'h0000_0204);
        checkOutput("stall2.ready", 32'(bus.in_ready), 32'd0);
        checkEntry("stall2", 3'b011, 32'h0001_2345, 32'h0000_0110, 1'b0);
        applyStimulus(1'b1, 32'h00A00193, 32'h0000_0204);
        checkEntry("stall3", 3'b011, 32'h0001_2345, 32'h0000_0110, 1'b0);

        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkEntry("release1", 3'b000, 32'h0000_0005, 32'h0000_0200, 1'b0);
        checkOutput("release1.ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("release2.valid", 32'(bus.out_valid), 32'd0);

        // Fill to TWO, then flush with a new instruction on offer.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00700213, 32'h0000_0300);
        applyStimulus(1'b1, 32'h00800293, 32'h0000_0304);
        checkOutput("fill.ready", 32'(bus.in_ready), 32'd0);
        checkEntry("fill", 3'b000, 32'h0000_0007, 32'h0000_0300, 1'b0);
        bus.flush = 1'b1;
        applyStimulus(1'b1, 32'h00900313, 32'h0000_0308);
        checkOutput("flush.valid", 32'(bus.out_valid), 32'd0);
        checkOutput("flush.ready", 32'(bus.in_ready), 32'd1);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("postflush.valid", 32'(bus.out_valid), 32'd0);

        // Flush while in_ready is high still discards the offered instruction.
        bus.flush = 1'b1;
        applyStimulus(1'b1, 32'h00100393, 32'h0000_0310);
        checkOutput("flushacc.valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("flushacc2.valid", 32'(bus.out_valid), 32'd0);

        applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0400);
        checkEntry("illegal", 3'b111, 32'h0000_0000, 32'h0000_0400, 1'b1);
        applyStimulus(1'b1, 32'h002081B3, 32'h0000_0404);
        checkEntry("rtype", 3'b111, 32'h0000_0000, 32'h0000_0404, 1'b0);
        applyStimulus(1'b1, 32'hFFFFF297, 32'h0000_0408);
        checkEntry("auipc", 3'b011, 32'hFFFF_FFFF, 32'h0000_0408, 1'b0);

        // Reach TWO, then assert reset between edges.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h00100393, 32'h0000_040C);
        checkOutput("pre_rst.ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async_rst");
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkReset("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
